// File: rtl/agc_sim_pkg.sv
// Shared constants and helpers for the NOR settle monitor: event record layout,
// default settle length and pointer sizing.
package agc_sim_pkg;

  localparam int SETTLE_DEFAULT = 2;
  localparam int RUN_W          = 4;
  localparam int EV_STAMP_LSB   = 0;

  // Event record is {rise, stamp[CNT_W-1:0]}; the rise flag sits just above the stamp.
  function automatic int ev_rise_pos(input int cnt_w);
    return cnt_w;
  endfunction

  function automatic int ev_width(input int cnt_w);
    return cnt_w + 1;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/nor_event_fifo.sv
// Synchronous event FIFO; a push into a full FIFO succeeds when a pop lands on the same edge.
module nor_event_fifo
  import agc_sim_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == (PTR_W+1)'(0));
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst_b && do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nor_settle_monitor.sv
// Settles a gate-modelled net, timestamps each accepted edge and queues it for a
// valid/ready consumer; a sticky flag records events lost to a full queue.
module nor_settle_monitor
  import agc_sim_pkg::*;
#(
  parameter logic IV     = 1'b0,
  parameter int   SETTLE = SETTLE_DEFAULT,
  parameter int   DEPTH  = 4,
  parameter int   CNT_W  = 16
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic             net,
  input  logic             ev_ready,
  input  logic             clr_ovf,
  output logic             ev_valid,
  output logic             ev_rise,
  output logic [CNT_W-1:0] ev_stamp,
  output logic             level,
  output logic [CNT_W-1:0] rise_count,
  output logic             overflow
);

  localparam int             EV_W     = ev_width(CNT_W);
  localparam int             RISE_POS = ev_rise_pos(CNT_W);
  localparam logic [RUN_W:0] SETTLE_V = (RUN_W+1)'(SETTLE);

  logic             samp;
  logic [RUN_W-1:0] run;
  logic [RUN_W:0]   run_inc;
  logic [CNT_W-1:0] ts;
  logic             settle_hit;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;
  logic [EV_W-1:0]  ev_in;
  logic [EV_W-1:0]  ev_out;

  always_comb begin
    run_inc    = {1'b0, run} + (RUN_W+1)'(1);
    settle_hit = (samp != level) && (run_inc == SETTLE_V);
    pop        = ev_valid && ev_ready;
    drop       = settle_hit && fifo_full && !pop;
    ev_in                            = '0;
    ev_in[RISE_POS]                  = ~level;
    ev_in[EV_STAMP_LSB +: CNT_W]     = ts;
  end

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      samp       <= IV;
      level      <= IV;
      run        <= '0;
      ts         <= '0;
      rise_count <= '0;
      overflow   <= 1'b0;
    end else begin
      samp <= net;
      ts   <= ts + CNT_W'(1);
      if (samp == level) begin
        run <= '0;
      end else if (settle_hit) begin
        level <= ~level;
        run   <= '0;
        if (!level) rise_count <= rise_count + CNT_W'(1);
      end else begin
        run <= run_inc[RUN_W-1:0];
      end
      // A drop on the same edge as a clear must leave the flag set.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  nor_event_fifo #(
    .WIDTH(EV_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (SIM_CLK),
    .rst_b(SIM_RST),
    .push (settle_hit),
    .pop  (pop),
    .din  (ev_in),
    .dout (ev_out),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ev_rise  = ev_out[RISE_POS];
  assign ev_stamp = ev_out[EV_STAMP_LSB +: CNT_W];

endmodule

// File: tb/tb_nor_settle_monitor.sv
// Directed bench for nor_settle_monitor (SETTLE=2, DEPTH=4, CNT_W=16, IV=0);
// edge numbers in comments count non-reset edges from release.
module tb_nor_settle_monitor;

  logic        SIM_CLK = 1'b0;
  logic        SIM_RST;
  logic        net;
  logic        ev_ready;
  logic        clr_ovf;
  logic        ev_valid;
  logic        ev_rise;
  logic [15:0] ev_stamp;
  logic        level;
  logic [15:0] rise_count;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  nor_settle_monitor #(
    .IV(1'b0), .SETTLE(2), .DEPTH(4), .CNT_W(16)
  ) dut (
    .SIM_CLK   (SIM_CLK),
    .SIM_RST   (SIM_RST),
    .net       (net),
    .ev_ready  (ev_ready),
    .clr_ovf   (clr_ovf),
    .ev_valid  (ev_valid),
    .ev_rise   (ev_rise),
    .ev_stamp  (ev_stamp),
    .level     (level),
    .rise_count(rise_count),
    .overflow  (overflow)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge SIM_CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic rise, input logic [15:0] stamp);
    chk({tag, "_valid"}, 32'(ev_valid), 32'd1);
    chk({tag, "_rise"},  32'(ev_rise),  32'(rise));
    chk({tag, "_stamp"}, 32'(ev_stamp), 32'(stamp));
  endtask

  task automatic pop_one;
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
  endtask

  initial begin
    SIM_RST = 1'b0; net = 1'b0; ev_ready = 1'b0; clr_ovf = 1'b0;

    // reset held over 3 edges while net toggles
    for (int i = 0; i < 3; i++) begin
      net = ~net;
      step(1);
    end
    chk("rst_valid",    32'(ev_valid),   32'd0);
    chk("rst_level",    32'(level),      32'd0);
    chk("rst_rise_cnt", 32'(rise_count), 32'd0);
    chk("rst_overflow", 32'(overflow),   32'd0);
    chk("rst_stamp",    32'(ev_stamp),   32'd0);
    chk("rst_rise",     32'(ev_rise),    32'd0);

    SIM_RST = 1'b1; net = 1'b0;
    step(10);                          // edges 0..9
    net = 1'b1;
    step(2);                           // edges 10,11
    chk("rise_not_yet", 32'(level), 32'd0);
    step(1);                           // edge 12: level flips
    chk("rise_level", 32'(level), 32'd1);
    chk_head("rise_ev", 1'b1, 16'd12);
    chk("rise_cnt1", 32'(rise_count), 32'd1);
    pop_one();                         // edge 13
    chk("pop_valid", 32'(ev_valid), 32'd0);
    chk("empty_stamp", 32'(ev_stamp), 32'd0);

    net = 1'b0;
    step(3);                           // fall at edge 16
    chk("fall_level", 32'(level), 32'd0);
    chk_head("fall_ev", 1'b0, 16'd16);
    pop_one();                         // edge 17

    // single-sample glitch
    net = 1'b1; step(1);               // edge 18
    net = 1'b0; step(4);               // edges 19..22
    chk("glitch_level", 32'(level),      32'd0);
    chk("glitch_valid", 32'(ev_valid),   32'd0);
    chk("glitch_cnt",   32'(rise_count), 32'd1);

    // two-sample pulse is accepted
    net = 1'b1; step(2);               // edges 23,24
    net = 1'b0; step(1);               // edge 25: rise
    chk("pulse_level", 32'(level), 32'd1);
    chk_head("pulse_ev", 1'b1, 16'd25);
    chk("pulse_cnt", 32'(rise_count), 32'd2);
    step(2);                           // edge 27: fall back
    chk("pulse_fall_level", 32'(level), 32'd0);
    chk_head("pulse_head_stable", 1'b1, 16'd25);
    pop_one();                         // edge 28
    chk_head("pulse_fall_ev", 1'b0, 16'd27);
    pop_one();                         // edge 29
    chk("pulse_drained", 32'(ev_valid), 32'd0);

    // overflow: five settled edges, no reads
    net = 1'b1; step(3);               // rise 32
    net = 1'b0; step(3);               // fall 35
    net = 1'b1; step(3);               // rise 38
    net = 1'b0; step(3);               // fall 41
    chk("full_no_ovf", 32'(overflow), 32'd0);
    net = 1'b1; step(3);               // rise 44 dropped
    chk("ovf_set",   32'(overflow),   32'd1);
    chk("ovf_level", 32'(level),      32'd1);
    chk("ovf_cnt",   32'(rise_count), 32'd5);
    chk_head("ovf_h0", 1'b1, 16'd32);
    pop_one();                         // edge 45
    chk_head("ovf_h1", 1'b0, 16'd35);
    pop_one();
    chk_head("ovf_h2", 1'b1, 16'd38);
    pop_one();
    chk_head("ovf_h3", 1'b0, 16'd41);
    pop_one();                         // edge 48
    chk("ovf_drained", 32'(ev_valid), 32'd0);
    chk("ovf_sticky",  32'(overflow), 32'd1);
    clr_ovf = 1'b1; step(1);           // edge 49
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // full FIFO, push and pop on the same edge
    net = 1'b0; step(3);               // fall 52
    net = 1'b1; step(3);               // rise 55
    net = 1'b0; step(3);               // fall 58
    net = 1'b1; step(3);               // rise 61
    net = 1'b0; step(2);               // edges 62,63
    pop_one();                         // edge 64: fall pushed, fall 52 popped
    chk("pp_no_ovf", 32'(overflow), 32'd0);
    chk_head("pp_h0", 1'b1, 16'd55);
    pop_one();
    chk_head("pp_h1", 1'b0, 16'd58);
    pop_one();
    chk_head("pp_h2", 1'b1, 16'd61);
    pop_one();
    chk_head("pp_h3", 1'b0, 16'd64);
    pop_one();                         // edge 68
    chk("pp_drained", 32'(ev_valid), 32'd0);

    // reset mid-run with two events queued
    net = 1'b1; step(3);               // rise 71
    net = 1'b0; step(3);               // fall 74
    net = 1'b1; step(2);               // edges 75,76: run = 1
    chk("mr_queued", 32'(ev_valid), 32'd1);
    SIM_RST = 1'b0; step(1);
    SIM_RST = 1'b1;
    chk("mr_valid", 32'(ev_valid),   32'd0);
    chk("mr_level", 32'(level),      32'd0);
    chk("mr_cnt",   32'(rise_count), 32'd0);
    chk("mr_stamp", 32'(ev_stamp),   32'd0);
    step(2);                           // post-reset edges 0,1
    chk("mr_full_settle", 32'(level), 32'd0);
    step(1);                           // edge 2: rise stamped with restarted ts
    chk("mr_level_up", 32'(level), 32'd1);
    chk_head("mr_ev", 1'b1, 16'd2);
    chk("mr_cnt1", 32'(rise_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
